nes_dbg_host: RTL and testbench

//  Host-side initiator of the NES single-step debug protocol. Takes one command request (cmd, data), serialises it as a
//  2-byte packet onto a UART tx byte stream, then collects the 13-byte status reply from the UART rx byte stream.
//  It presents the reply as a parallel status record with one-cycle valid. Sits between a test sequencer (or soft

---
 rtl/nes_dbg_host_if.sv | 43 ++++
 rtl/nes_dbg_host.sv | 162 ++++++++++++++++
 tb/tb_nes_dbg_host.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_dbg_host_if.sv
// Byte-stream and status-record signals between nes_dbg_host and its sequencer/UART FIFO pair.
// The slave modport is the host engine's view; master is the surrounding environment's view.
interface nes_dbg_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [7:0]  req_data;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_full;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        rx_rd;
  logic        rsp_valid;
  logic [7:0]  rsp_phase;
  logic [7:0]  rsp_ir;
  logic [15:0] rsp_addr;
  logic [7:0]  rsp_dout;
  logic        rsp_rnw;
  logic [15:0] rsp_pc;
  logic [7:0]  rsp_x;
  logic [7:0]  rsp_y;
  logic [7:0]  rsp_ac;
  logic [7:0]  rsp_s;
  logic [7:0]  rsp_p;
  logic        proto_err;
  logic        timeout;
  logic [7:0]  stray_cnt;

  modport slave (
    input  req_valid, req_cmd, req_data, tx_full, rx_data, rx_empty,
    output req_ready, tx_data, tx_wr, rx_rd, rsp_valid, rsp_phase, rsp_ir, rsp_addr,
           rsp_dout, rsp_rnw, rsp_pc, rsp_x, rsp_y, rsp_ac, rsp_s, rsp_p,
           proto_err, timeout, stray_cnt
  );

  modport master (
    output req_valid, req_cmd, req_data, tx_full, rx_data, rx_empty,
    input  req_ready, tx_data, tx_wr, rx_rd, rsp_valid, rsp_phase, rsp_ir, rsp_addr,
           rsp_dout, rsp_rnw, rsp_pc, rsp_x, rsp_y, rsp_ac, rsp_s, rsp_p,
           proto_err, timeout, stray_cnt
  );
endinterface

// File: rtl/nes_dbg_host.sv
// nes_dbg_host: host side of the NES single-step debug link (2-byte command out, 13-byte status reply in).
// Define HOST_TIMEOUT_EN to abort replies not completed within TIMEOUT_CYC cycles; otherwise RX waits forever.
module nes_dbg_host #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input logic           clk_in,
  input logic           rst,
  nes_dbg_host_if.slave bus
);
  localparam int         RSP_LEN  = 13;
  localparam logic [3:0] LAST_IDX = 4'(RSP_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, TX_CMD, TX_DATA, RX_WAIT, RX_LATCH, DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [7:0]               cmd_q, data_q, strayCnt_q;
  logic [3:0]               idx_q;
  logic [8*(RSP_LEN-1)-1:0] shadow_q;
  logic [8*RSP_LEN-1:0]     rsp_q;
  logic                     protoErr_q, txGap_q;
  logic                     txWr, rxRd, accept, timeoutHit;
  logic [7:0]               txData;
  logic                     phaseBad, rnwBad;

  assign phaseBad = (cmd_q == 8'd0) ? (bus.rx_data != 8'd0)
                                    : (bus.rx_data != 8'd1 && bus.rx_data != 8'd2);
  assign rnwBad   = |bus.rx_data[7:1];

`ifdef HOST_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] tmoCnt_q;
  logic        timeout_q;

  assign timeoutHit = (tmoCnt_q == TMO_LAST);

  // Counter restarts on the data-byte write and only advances while a reply is outstanding.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tmoCnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) timeout_q <= 1'b0;
      if (state_q == TX_DATA && txWr) begin
        tmoCnt_q <= '0;
      end else if (state_q == RX_WAIT || state_q == RX_LATCH) begin
        tmoCnt_q <= tmoCnt_q + 32'd1;
        if (timeoutHit && state_d == IDLE) timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = ^TIMEOUT_CYC;
  assign timeoutHit       = 1'b0;
  assign bus.timeout      = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    txWr    = 1'b0;
    rxRd    = 1'b0;
    accept  = 1'b0;
    txData  = (state_q == TX_DATA) ? data_q : cmd_q;
    case (state_q)
      IDLE: begin
        rxRd = !bus.rx_empty;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = TX_CMD;
        end
      end
      TX_CMD: begin
        if (!bus.tx_full) begin
          txWr    = 1'b1;
          state_d = TX_DATA;
        end
      end
      // txGap_q enforces the idle cycle the FIFO write line needs between strobes.
      TX_DATA: begin
        if (!bus.tx_full && !txGap_q) begin
          txWr    = 1'b1;
          state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (timeoutHit) begin
          state_d = IDLE;
        end else if (!bus.rx_empty) begin
          rxRd    = 1'b1;
          state_d = RX_LATCH;
        end
      end
      RX_LATCH: begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else if (timeoutHit)   state_d = IDLE;
        else                   state_d = RX_WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cmd_q      <= '0;
      data_q     <= '0;
      strayCnt_q <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      rsp_q      <= '0;
      protoErr_q <= 1'b0;
      txGap_q    <= 1'b0;
    end else begin
      txGap_q <= txWr;
      if (accept) begin
        cmd_q      <= bus.req_cmd;
        data_q     <= bus.req_data;
        idx_q      <= '0;
        protoErr_q <= 1'b0;
      end
      if (state_q == IDLE && rxRd && strayCnt_q != 8'hFF) strayCnt_q <= strayCnt_q + 8'd1;
      // Bytes 0..11 collect in the shadow; the last byte lands straight in the visible record.
      if (state_q == RX_LATCH) begin
        if ((idx_q == 4'd0 && phaseBad) || (idx_q == 4'd5 && rnwBad)) protoErr_q <= 1'b1;
        if (idx_q == LAST_IDX) begin
          rsp_q <= {bus.rx_data, shadow_q};
        end else begin
          shadow_q[{idx_q, 3'b000} +: 8] <= bus.rx_data;
          idx_q                          <= idx_q + 4'd1;
        end
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.tx_wr     = txWr;
  assign bus.tx_data   = txData;
  assign bus.rx_rd     = rxRd;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_phase = rsp_q[7:0];
  assign bus.rsp_ir    = rsp_q[15:8];
  assign bus.rsp_addr  = {rsp_q[23:16], rsp_q[31:24]};
  assign bus.rsp_dout  = rsp_q[39:32];
  assign bus.rsp_rnw   = rsp_q[40];
  assign bus.rsp_pc    = {rsp_q[55:48], rsp_q[63:56]};
  assign bus.rsp_x     = rsp_q[71:64];
  assign bus.rsp_y     = rsp_q[79:72];
  assign bus.rsp_ac    = rsp_q[87:80];
  assign bus.rsp_s     = rsp_q[95:88];
  assign bus.rsp_p     = rsp_q[103:96];
  assign bus.proto_err = protoErr_q;
  assign bus.stray_cnt = strayCnt_q;
endmodule

// File: tb/tb_nes_dbg_host.sv
// Scoreboard bench for nes_dbg_host: requests push expected tx bytes and status records, a monitor pops them.
// Runs in both builds; the HOST_TIMEOUT_EN build exercises the abort path, the default build the indefinite wait.
module tb_nes_dbg_host;
  localparam int TMO = 1000;

  typedef struct packed {
    logic [103:0] rec;
    logic         perr;
  } exp_t;

  logic         clk_in = 1'b0;
  logic         rst    = 1'b1;
  int           checks = 0;
  int           errors = 0;
  int           expStray = 0;
  logic [7:0]   rxQ[$];
  logic [7:0]   txExpQ[$];
  exp_t         rspExpQ[$];
  logic [103:0] lastRec = '0;
  bit           lastWr = 1'b0;
  bit           rdSeen;
  bit           tmoSeen;
  exp_t         monE;
  exp_t         stimE;
  logic [7:0]   rep [13];
  logic [7:0]   rCmd;
  bit           drained;

  nes_dbg_host_if bus();

  nes_dbg_host #(.TIMEOUT_CYC(TMO)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Status record in bench order, built from reply bytes by the protocol's field map.
  function automatic logic [103:0] expectRecord(input logic [7:0] b [13]);
    logic [15:0] addr, pc;
    addr = 16'(b[2]) * 16'd256 + 16'(b[3]);
    pc   = 16'(b[6]) * 16'd256 + 16'(b[7]);
    return {b[0], b[1], addr, b[4], 7'd0, b[5][0], pc, b[8], b[9], b[10], b[11], b[12]};
  endfunction

  function automatic logic expectErr(input logic [7:0] cmd, input logic [7:0] b0, input logic [7:0] b5);
    logic e;
    if (cmd == 8'd0) e = (b0 != 8'd0);
    else             e = !(b0 == 8'd1 || b0 == 8'd2);
    if (b5 >= 8'd2) e = 1'b1;
    return e;
  endfunction

  function automatic logic [103:0] dutRecord();
    return {bus.rsp_phase, bus.rsp_ir, bus.rsp_addr, bus.rsp_dout, 7'd0, bus.rsp_rnw, bus.rsp_pc,
            bus.rsp_x, bus.rsp_y, bus.rsp_ac, bus.rsp_s, bus.rsp_p};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_req_ready", 128'(bus.req_ready), 128'(1));
    checkOutput("rst_strobes", 128'({bus.tx_wr, bus.rx_rd, bus.rsp_valid}), 128'(0));
    checkOutput("rst_tx_data", 128'(bus.tx_data), 128'(0));
    checkOutput("rst_record", 128'(dutRecord()), 128'(0));
    checkOutput("rst_flags", 128'({bus.proto_err, bus.timeout}), 128'(0));
    checkOutput("rst_stray", 128'(bus.stray_cnt), 128'(0));
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #2;
  endtask

  // Issue one request, feed nSend reply bytes at a random pace, wait until the scoreboard drains.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] reply [13],
                               input int nSend, input int holdFull, input bit randFull);
    bit   acc;
    bit   done;
    int   sent;
    exp_t e;
    acc  = 1'b0;
    done = 1'b0;
    sent = 0;
    txExpQ.push_back(cmd);
    txExpQ.push_back(data);
    if (nSend == 13) begin
      e.rec  = expectRecord(reply);
      e.perr = expectErr(cmd, reply[0], reply[5]);
      rspExpQ.push_back(e);
      lastRec = e.rec;
    end
    bus.tx_full   = (holdFull > 0);
    bus.req_cmd   = cmd;
    bus.req_data  = data;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = bus.req_ready;
      cycle();
    end
    bus.req_valid = 1'b0;
    checkOutput("req_accept", 128'(acc), 128'(1));
    if (!acc) begin
      txExpQ.delete();
      rspExpQ.delete();
      return;
    end
    checkOutput("err_cleared", 128'({bus.proto_err, bus.timeout}), 128'(0));
    if (holdFull > 0) begin
      repeat (holdFull) cycle();
      bus.tx_full = 1'b0;
      @(negedge clk_in);
      checkOutput("cmd_after_release", 128'(bus.tx_wr), 128'(1));
      cycle();
    end
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (sent < nSend && $urandom_range(0, 1) == 1) begin
        rxQ.push_back(reply[sent]);
        sent++;
      end
      bus.tx_full = randFull && ($urandom_range(0, 3) == 0);
      cycle();
      done = (sent == nSend) && (txExpQ.size() == 0) && (rspExpQ.size() == 0) && (rxQ.size() == 0);
    end
    bus.tx_full = 1'b0;
    checkOutput("txn_done", 128'(done), 128'(1));
    if (!done) begin
      txExpQ.delete();
      rspExpQ.delete();
    end
  endtask

  task automatic injectStray(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < n; i++) rxQ.push_back(8'($urandom));
    for (int cyc = 0; cyc < n + 50 && !ok; cyc++) begin
      cycle();
      ok = (rxQ.size() == 0);
    end
    repeat (2) cycle();
    expStray = (expStray + n > 255) ? 255 : expStray + n;
    checkOutput("stray_drained", 128'(ok), 128'(1));
    checkOutput("stray_cnt", 128'(bus.stray_cnt), 128'(expStray));
  endtask

  // rx FIFO model: read data appears the cycle after rx_rd.
  initial begin
    bus.rx_empty = 1'b1;
    bus.rx_data  = 8'h00;
    forever begin
      @(posedge clk_in);
      rdSeen = bus.rx_rd;
      #1;
      if (rdSeen && rxQ.size() > 0) bus.rx_data = rxQ.pop_front();
      bus.rx_empty = (rxQ.size() == 0);
    end
  end

  always @(negedge clk_in) begin
    if (rst) begin
      lastWr = 1'b0;
    end else begin
      if (bus.tx_wr) begin
        checkOutput("tx_wr_while_full", 128'(bus.tx_full), 128'(0));
        checkOutput("tx_wr_gap", 128'(lastWr), 128'(0));
        if (txExpQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL tx_unexpected: got byte %0h, expected no write", bus.tx_data);
        end else begin
          checkOutput("tx_byte", 128'(bus.tx_data), 128'(txExpQ.pop_front()));
        end
      end
      lastWr = bus.tx_wr;
      if (bus.rsp_valid) begin
        if (rspExpQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rsp_unexpected: got rsp_valid=1, expected 0");
        end else begin
          monE = rspExpQ.pop_front();
          checkOutput("rsp_record", 128'(dutRecord()), 128'(monE.rec));
          checkOutput("rsp_proto_err", 128'(bus.proto_err), 128'(monE.perr));
        end
      end
    end
  end

  initial begin
    #900000;
    errors++;
    $display("[TB] FAIL watchdog: got no end of run, expected $finish before 90000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = 8'h00;
    bus.req_data  = 8'h00;
    bus.tx_full   = 1'b0;
    rst           = 1'b1;
    repeat (3) cycle();
    checkResetValues();
    rst = 1'b0;
    cycle();

    $display("[TB] strays while idle");
    injectStray(3);

    $display("[TB] restart request");
    rep = '{8'h00, 8'hA9, 8'hFF, 8'hFC, 8'h00, 8'h01, 8'hFF, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hFD, 8'h24};
    applyStimulus(8'h00, 8'h00, rep, 13, 0, 1'b0);
    checkOutput("t1_addr", 128'(bus.rsp_addr), 128'(16'hFFFC));
    checkOutput("t1_rnw", 128'(bus.rsp_rnw), 128'(1));
    checkOutput("t1_s_p", 128'({bus.rsp_s, bus.rsp_p}), 128'(16'hFD24));
    checkOutput("t1_proto_err", 128'(bus.proto_err), 128'(0));

    $display("[TB] step request");
    for (int k = 0; k < 13; k++) rep[k] = 8'($urandom);
    rep[0] = 8'h01;
    rep[5] = 8'h00;
    applyStimulus(8'h01, 8'hEA, rep, 13, 0, 1'b0);
    checkOutput("t2_phase", 128'(bus.rsp_phase), 128'(1));

    $display("[TB] tx_full hold");
    for (int k = 0; k < 13; k++) rep[k] = 8'($urandom);
    rep[0] = 8'h02;
    rep[5] = 8'h01;
    applyStimulus(8'h01, 8'h3C, rep, 13, 10, 1'b0);

    $display("[TB] phase mismatch");
    for (int k = 0; k < 13; k++) rep[k] = 8'($urandom);
    rep[0] = 8'h02;
    rep[5] = 8'h00;
    applyStimulus(8'h00, 8'h11, rep, 13, 0, 1'b0);
    checkOutput("t4_proto_err", 128'(bus.proto_err), 128'(1));

    $display("[TB] random requests");
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0:       rCmd = 8'h00;
        1:       rCmd = 8'h01;
        default: rCmd = 8'($urandom_range(2, 255));
      endcase
      for (int k = 0; k < 13; k++) rep[k] = 8'($urandom);
      if ($urandom_range(0, 4) != 0) rep[0] = (rCmd == 8'h00) ? 8'h00 : 8'($urandom_range(1, 2));
      else                           rep[0] = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0) rep[5] = 8'($urandom_range(0, 1));
      applyStimulus(rCmd, 8'($urandom), rep, 13, 0, 1'b1);
    end

    for (int k = 0; k < 13; k++) rep[k] = 8'($urandom);
    rep[0] = 8'h01;
    rep[5] = 8'h00;
`ifdef HOST_TIMEOUT_EN
    $display("[TB] reply stalls after 7 bytes, abort expected");
    applyStimulus(8'h01, 8'h55, rep, 7, 0, 1'b0);
    checkOutput("timeout_early", 128'(bus.timeout), 128'(0));
    tmoSeen = 1'b0;
    for (int cyc = 0; cyc < 1200 && !tmoSeen; cyc++) begin
      cycle();
      tmoSeen = bus.timeout;
    end
    checkOutput("timeout_set", 128'(tmoSeen), 128'(1));
    checkOutput("rsp_held", 128'(dutRecord()), 128'(lastRec));
`else
    $display("[TB] reply stalls after 7 bytes, then resumes");
    applyStimulus(8'h01, 8'h55, rep, 7, 0, 1'b0);
    repeat (200) cycle();
    checkOutput("no_timeout", 128'(bus.timeout), 128'(0));
    stimE.rec  = expectRecord(rep);
    stimE.perr = expectErr(8'h01, rep[0], rep[5]);
    rspExpQ.push_back(stimE);
    lastRec = stimE.rec;
    for (int k = 7; k < 13; k++) rxQ.push_back(rep[k]);
    drained = 1'b0;
    for (int cyc = 0; cyc < 200 && !drained; cyc++) begin
      cycle();
      drained = (rspExpQ.size() == 0);
    end
    checkOutput("late_reply_done", 128'(drained), 128'(1));
`endif

    $display("[TB] stray saturation");
    injectStray(300);

    $display("[TB] reset mid-reply");
    for (int k = 0; k < 13; k++) rep[k] = 8'($urandom);
    applyStimulus(8'h01, 8'h77, rep, 4, 0, 1'b0);
    rst = 1'b1;
    #1;
    rxQ.delete();
    txExpQ.delete();
    rspExpQ.delete();
    checkResetValues();
    repeat (2) cycle();
    rst      = 1'b0;
    expStray = 0;
    cycle();

    $display("[TB] recovery after reset");
    for (int k = 0; k < 13; k++) rep[k] = 8'($urandom);
    rep[0] = 8'h00;
    rep[5] = 8'h01;
    applyStimulus(8'h00, 8'h00, rep, 13, 0, 1'b0);
    checkOutput("recover_stray", 128'(bus.stray_cnt), 128'(0));

    repeat (5) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
